// File: rtl/md_sequencer.sv
// Multiply/divide sequencer with HI/LO registers for the EX stage.
// Operands are latched at start; a cycle counter alone sets the visible latency.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               lat_en;
  logic [1:0]         op_q;
  logic [31:0]        a_q, b_q;
  logic [63:0]        res;

  function automatic logic [63:0] mul_res(input logic is_unsigned,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, prod;
    if (is_unsigned) begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end else begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end
    prod = sa * sb;
    return prod;
  endfunction

  // Returns {remainder, quotient}; a zero divisor is masked so nothing goes X.
  function automatic logic [63:0] div_res(input logic is_unsigned,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic        [31:0] bs, q, r;
    logic signed [31:0] sa, sb;
    bs = (b == 32'd0) ? 32'd1 : b;
    sa = a;
    sb = bs;
    if (is_unsigned) begin
      q = a / bs;
      r = a % bs;
    end else if (a == 32'h8000_0000 && bs == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {r, q};
  endfunction

  assign res = op_q[1] ? div_res(op_q[0], a_q, b_q) : mul_res(op_q[0], a_q, b_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    lat_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (mdOp)
            3'd0, 3'd1: begin
              lat_en  = 1'b1;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
              busy_d  = 1'b1;
            end
            3'd2, 3'd3: begin
              lat_en  = 1'b1;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = RUN;
              busy_d  = 1'b1;
            end
            3'd4:    hi_d = srcA;
            3'd5:    lo_d = srcA;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Starts arriving here are protocol violations and are dropped.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          if (!(op_q[1] && b_q == 32'd0)) begin
            hi_d = res[63:32];
            lo_d = res[31:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lat_en) begin
      op_q <= mdOp[1:0];
      a_q  <= srcA;
      b_q  <= srcB;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed vector table, hand-written corner sequences
// and randomized operations checked against an arithmetic reference model.
module tb_md_sequencer;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk, reset, start;
  logic [2:0]  mdOp;
  logic [31:0] srcA, srcB;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi, m_lo;

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mdOp(mdOp),
    .srcA(srcA), .srcB(srcB), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: results from plain 64-bit arithmetic on the operands.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cycles);
    longint          sa, sb, q, r, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    cycles = 0;
    case (op)
      3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; cycles = MC; end
      3'd1: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; cycles = MC; end
      3'd2: begin
        cycles = DC;
        if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      end
      3'd3: begin
        cycles = DC;
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue one op, scramble inputs while it runs, optionally fire a stray start
  // at busy cycle inj, then check latency, done pulse and HI/LO.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int inj, input string tag);
    int exp_cyc, nb, dn;
    @(negedge clk);
    start = 1'b1; mdOp = op; srcA = a; srcB = b;
    @(posedge clk);
    #1;
    start = 1'b0; srcA = $urandom; srcB = $urandom; mdOp = 3'($urandom);
    model(op, a, b, exp_cyc);
    nb = 0; dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (!busy) break;
      nb++;
      if (done) dn++;
      srcA = $urandom; srcB = $urandom;
      if (nb == inj) begin
        start = 1'b1; mdOp = 3'($urandom_range(0, 5));
      end
    end
    chk({tag, " busy_cycles"}, nb, exp_cyc);
    chk({tag, " done_during_busy"}, dn, 0);
    chk({tag, " done_end"}, {31'd0, done}, {31'd0, exp_cyc > 0});
    chk({tag, " hi"}, hi, m_hi);
    chk({tag, " lo"}, lo, m_lo);
    @(negedge clk);
    chk({tag, " done_after"}, {31'd0, done}, 32'd0);
    chk({tag, " busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd4, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFD};
    vecs[4]  = '{3'd5, 32'h00005678, 32'd0,        32'h00001234, 32'h00005678};
    vecs[5]  = '{3'd3, 32'd99,       32'd0,        32'h00001234, 32'h00005678};
    vecs[6]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{3'd3, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF};
    vecs[9]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[10] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[11] = '{3'd6, 32'd1,        32'd2,        32'hFFFFFFFE, 32'h00000001};
    vecs[12] = '{3'd2, 32'd5,        32'd0,        32'hFFFFFFFE, 32'h00000001};
    vecs[13] = '{3'd2, 32'hFFFFFFF8, 32'd3,        32'hFFFFFFFE, 32'hFFFFFFFE};

    reset = 1'b0; start = 1'b0; mdOp = 3'd0; srcA = '0; srcB = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d table_lo", i), lo, vecs[i].exp_lo);
    end

    // Stray start at busy cycle 2 must not disturb the running mult.
    do_op(3'd0, 32'd6, 32'd7, 2, "mult_inject");
    chk("mult_inject hi_fixed", hi, 32'd0);
    chk("mult_inject lo_fixed", lo, 32'd42);

    // Reset in the middle of a run aborts it without commit.
    @(negedge clk);
    start = 1'b1; mdOp = 3'd0; srcA = 32'd9; srcB = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("abort no_done", {31'd0, done}, 32'd0);
    end
    chk("abort hi_after", hi, 32'd0);

    do_op(3'd1, 32'd2, 32'd3, -1, "multu_scramble");
    chk("multu_scramble lo_fixed", lo, 32'd6);
    chk("multu_scramble hi_fixed", hi, 32'd0);

    for (int i = 0; i < 200; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) a = {{24{a[7]}}, a[7:0]};
      do_op(op, a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1,
            $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle multiply/divide sequencer with HI/LO registers for the pipelined MIPS core. It sits beside the ALU in the EX stage.
- The decoder raises `start` with an `mdOp` code when one of these instructions reaches EX: mult, multu, div, divu, mthi, mtlo.
- The block latches the operands and counts out the fixed latency, then commits the result to HI/LO.
- It exports `busy` so the hazard unit can stall later MD and mfhi/mflo instructions.

Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu (≥1)
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu (≥1)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  EX-stage MD instruction valid this cycle
- mdOp  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7=reserved (no-op)
- srcA  input  32  rs value (multiplicand/dividend; mthi/mtlo data)
- srcB  input  32  rt value (multiplier/divisor)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse in the cycle HI/LO first show a new mult/div result
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (reset=0, asynchronous):
  - hi=0, lo=0, busy=0, done=0; FSM goes to IDLE; counter cleared.
  - Reset asserted mid-operation aborts it with no commit.
- FSM states: IDLE and RUN.
- IDLE, start=1, mdOp in 0..3, at edge T:
  - Latch srcA, srcB and mdOp.
  - Load counter with N (MULT_CYCLES for ops 0/1, DIV_CYCLES for ops 2/3).
  - Go to RUN; busy=1 from T.
- RUN:
  - Counter decrements each edge.
  - At edge T+N: write hi/lo, go to IDLE, busy=0, done=1 for exactly one cycle.
  - busy is therefore high for exactly N cycles.
- IDLE, start=1, mdOp=4 (mthi) or 5 (mtlo):
  - hi (or lo) ← srcA at that edge.
  - busy stays 0 and done stays 0.
- start with mdOp 6/7: no state change.
- start while busy=1: ignored; the operands are not relatched. Upstream must stall, so this is a protocol violation, but it must not corrupt the running operation.
- mult: {hi,lo} = signed 64-bit product of srcA×srcB.
- multu: {hi,lo} = unsigned 64-bit product.
- div:
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- divu: unsigned quotient to lo, remainder to hi.
- Divisor = 0 (div/divu): full latency and done pulse occur, but hi/lo stay unchanged.
- Result computation:
  - Results come from the latched operands only, so srcA/srcB may change freely after the start edge.
  - A combinational multiply/divide of the latched operands is acceptable; the counter alone sets the observable latency.
- Outputs hi/lo/busy/done are registers; they have no combinational path from the inputs.

Test Plan:
- Reset, then mult: reset low, release; start, mdOp=0, srcA=0xFFFFFFFE(-2), srcB=3.
  - busy high exactly 5 cycles, done pulses once.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Same operands as multu (mdOp=1) → hi=0x00000002, lo=0xFFFFFFFA after 5 busy cycles.
- div, mdOp=2, srcA=-7 (0xFFFFFFF9), srcB=2:
  - busy 10 cycles.
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu by zero: mthi 0x1234, mtlo 0x5678 (each changes immediately, busy never rises); then divu srcB=0.
  - 10 busy cycles, done pulse.
  - hi=0x1234, lo=0x5678 unchanged.
- Start during busy and reset mid-run:
  - mult 6×7, then start div 100/3 at busy cycle 2 → hi=0, lo=42 after the original 5 cycles; the div is never executed.
  - Then start mult again and drive reset low at busy cycle 3 → hi=lo=0, busy=0 immediately, no done pulse.
- Operand change after start: start multu 2×3, then change srcA/srcB every cycle → lo=6, hi=0.
